// File: rtl/sd_demodulator.sv
// rtl/sd_demodulator.sv - sinc^3 CIC decimator recovering Q-format samples from a 1-bit sigma-delta stream
// Define SD_DEMODULATOR_ROUND_EN to round half toward +inf instead of truncating on the final shift.
module sd_demodulator #(
    parameter int W     = 16,
    parameter int Q     = 12,
    parameter int LOG2R = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic                in,
    output logic signed [W-1:0] out,
    output logic                out_valid
);

    localparam int B = 2 + 3 * LOG2R;
    localparam int S = 3 * LOG2R - Q;

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_next;
    logic   valid_next;

    logic signed [B-1:0] i1, i2, i3;
    logic signed [B-1:0] d1, d2, d3;
    logic [LOG2R-1:0]    dcnt;

    logic signed [B-1:0] x;
    logic signed [B-1:0] i1_new, i2_new, i3_new;
    logic signed [B-1:0] c1, c2, c3, c3_adj;
    logic                dec_event;

    assign x = in ? {{(B-1){1'b0}}, 1'b1} : {B{1'b1}};

    // Integrator chain: each stage sees the freshly updated value of the stage before it.
    assign i1_new = i1 + x;
    assign i2_new = i2 + i1_new;
    assign i3_new = i3 + i2_new;

    assign dec_event = enb && (&dcnt);

    // Comb chain; all differences wrap modulo 2**B, which is exact for a CIC.
    assign c1 = i3_new - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

`ifdef SD_DEMODULATOR_ROUND_EN
    localparam int SR = (S > 0) ? (S - 1) : 0;
    localparam logic [B-1:0] RND = (S > 0) ? ({{(B-1){1'b0}}, 1'b1} << SR) : {B{1'b0}};
    assign c3_adj = c3 + $signed(RND);
`else
    assign c3_adj = c3;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            i1   <= '0;
            i2   <= '0;
            i3   <= '0;
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            dcnt <= '0;
            out  <= '0;
        end else if (enb) begin
            i1   <= i1_new;
            i2   <= i2_new;
            i3   <= i3_new;
            dcnt <= dcnt + LOG2R'(1);
            if (dec_event) begin
                d1  <= i3_new;
                d2  <= c1;
                d3  <= c2;
                out <= W'(c3_adj >>> S);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WARM0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
        end
    end

    // The first two decimated samples still contain start-up transients of the comb delays.
    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        if (dec_event) begin
            case (state)
                WARM0:   state_next = WARM1;
                WARM1:   state_next = RUN;
                RUN: begin
                    state_next = RUN;
                    valid_next = 1'b1;
                end
                default: state_next = WARM0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_demodulator.sv
// tb/tb_sd_demodulator.sv - directed and LFSR checks of sd_demodulator against a direct sinc^3 FIR model
module tb_sd_demodulator;

    localparam int W     = 16;
    localparam int LOG2R = 5;
    localparam int R     = 32;
    localparam int S     = 3;
    localparam int NH    = 3 * R - 2;
    localparam int HMAX  = 4096;

    logic clk = 1'b0;
    logic reset, enb, in;
    logic signed [W-1:0] out;
    logic out_valid;

    sd_demodulator #(.W(W), .Q(12), .LOG2R(LOG2R)) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int h [NH];
    int xs [HMAX];
    int nx, nev, m_out, m_valid;
    int w1, w2;
    int first_ne, pulses, last_clk, gap;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Direct-form sinc^3 model: FIR over the bit history since reset.
    function automatic int fir_out();
        int acc = 0;
        int lim = (nx < NH) ? nx : NH;
        for (int k = 0; k < lim; k++) acc += h[k] * xs[nx-1-k];
`ifdef SD_DEMODULATOR_ROUND_EN
        acc = acc + (1 << (S - 1));
`endif
        return acc >>> S;
    endfunction

    task automatic step(input logic e, input logic b);
        enb = e;
        in  = b;
        @(posedge clk);
        #1;
        if (reset) begin
            nx = 0; nev = 0; m_out = 0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (e && nx < HMAX) begin
                xs[nx] = b ? 1 : -1;
                nx++;
                if (nx % R == 0) begin
                    nev++;
                    m_out   = fir_out();
                    m_valid = (nev >= 3) ? 1 : 0;
                end
            end
        end
        chk("model_valid", out_valid, m_valid);
        chk("model_out", out, m_out);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_pat(input int nenb, input logic [3:0] pat, input int plen,
                           input int period, input int exp_val);
        int ne = 0;
        int clkn = 0;
        logic e, b;
        first_ne = -1; pulses = 0; last_clk = -1; gap = 0; w1 = 0; w2 = 0;
        while (ne < nenb) begin
            e = (clkn % period == 0);
            b = pat[ne % plen];
            step(e, b);
            clkn++;
            if (e) begin
                ne++;
                if (ne == R)     w1 = out;
                if (ne == 2 * R) w2 = out;
            end
            if (out_valid) begin
                pulses++;
                if (first_ne < 0) first_ne = ne;
                else chk("cadence_clks", clkn - last_clk, R * period);
                last_clk = clkn;
                chk("valid_out", out, exp_val);
            end
        end
    endtask

    initial begin
        logic [15:0] lfsr;
        logic e;
        for (int k = 0; k < NH; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a+b+c]++;
        nx = 0; nev = 0; m_out = 0; m_valid = 0;
        enb = 1'b0; in = 1'b0;

        // constant +1, enb every clock; reset cycles also carry enb which must be dropped
        do_reset();
        chk("reset_out", out, 0);
        chk("reset_valid", out_valid, 0);
        run_pat(6 * R, 4'b0001, 1, 1, 4096);
        chk("p1_first", first_ne, 96);
        chk("p1_pulses", pulses, 4);
        chk("p1_warm1", w1, 748);
        chk("p1_warm2", w2, 3476);

        // constant -1
        do_reset();
        run_pat(5 * R, 4'b0000, 1, 1, -4096);
        chk("m1_first", first_ne, 96);
        chk("m1_pulses", pulses, 3);
        chk("m1_warm1", w1, -748);

        // alternating 1,0
        do_reset();
        run_pat(5 * R, 4'b0001, 2, 1, 0);
        chk("alt_pulses", pulses, 3);

        // 1,1,1,0 -> mean +0.5
        do_reset();
        run_pat(5 * R, 4'b0111, 4, 1, 2048);
        chk("duty_pulses", pulses, 3);

        // enb one clock in three
        do_reset();
        run_pat(5 * R, 4'b0001, 1, 3, 4096);
        chk("slow_first", first_ne, 96);
        chk("slow_pulses", pulses, 3);

        // reset in the middle of a window
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
        chk("mid_out_before", out, 748);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_valid", out_valid, 0);
        run_pat(4 * R, 4'b0001, 1, 1, 4096);
        chk("mid_first", first_ne, 96);
        chk("mid_pulses", pulses, 2);

        // pseudo-random bitstream with irregular strobes against the FIR model
        do_reset();
        lfsr = 16'hACE1;
        for (int i = 0; i < 20 * R; i++) begin
            e = ($urandom_range(0, 3) != 0);
            step(e, lfsr[0]);
            if (e) lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
        chk("lfsr_events_seen", (nev >= 3) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
